// File: rtl/reg_ctrl_seq.sv
// Command sequencer for the downstream register bank: turns one accepted
// command into a timed clr/pre/load pulse or an LSB-first serial stream on d.
module reg_ctrl_seq #(
  parameter int DW      = 8,
  parameter int LEN_W   = 3,
  parameter int PULSE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             clr,
  output logic             pre,
  output logic             load,
  output logic             data,
  output logic             d,
  output logic             busy,
  output logic             done
);

  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_STREAM, S_GAP} state_t;
  typedef enum logic [1:0] {OP_CLEAR, OP_PRESET, OP_LOAD, OP_STREAM} op_t;

  state_t             r_state, w_state;
  op_t                r_op, w_op, w_pop;
  logic               r_ldval, w_ldval;
  logic [DW-1:0]      r_shift, w_shift;
  logic [LEN_W-1:0]   r_cnt, w_cnt;
  logic [LEN_W-1:0]   r_last, w_last;
  logic [PCW-1:0]     r_pcnt, w_pcnt;
  logic               w_pulse_on, w_pval;
  logic               w_d, w_done;
  logic [LEN_W-1:0]   w_len_clamped;

  assign cmd_ready     = (r_state == S_IDLE) & ~rst;
  assign w_len_clamped = (int'(cmd_len) > DW - 1) ? LEN_W'(DW - 1) : cmd_len;

  // Every output strobe is registered from the next-state decode, so the
  // strobe appears the cycle after the edge that enters the state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state    = r_state;
    w_op       = r_op;
    w_ldval    = r_ldval;
    w_shift    = r_shift;
    w_cnt      = r_cnt;
    w_last     = r_last;
    w_pcnt     = r_pcnt;
    w_pulse_on = 1'b0;
    w_pop      = r_op;
    w_pval     = r_ldval;
    w_d        = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op = op_t'(cmd_op);
          if (op_t'(cmd_op) == OP_STREAM) begin
            w_state = S_STREAM;
            w_cnt   = '0;
            w_last  = w_len_clamped;
            w_d     = cmd_data[0];
            w_shift = cmd_data >> 1;
          end else begin
            w_state    = S_PULSE;
            w_pcnt     = '0;
            w_ldval    = cmd_data[0];
            w_pulse_on = 1'b1;
            w_pop      = op_t'(cmd_op);
            w_pval     = cmd_data[0];
          end
        end
      end
      S_PULSE: begin
        if (r_pcnt == PCW'(PULSE_W - 1)) begin
          w_state = S_GAP;
          w_done  = 1'b1;
        end else begin
          w_pcnt     = r_pcnt + 1'b1;
          w_pulse_on = 1'b1;
        end
      end
      S_STREAM: begin
        if (r_cnt == r_last) begin
          w_state = S_GAP;
          w_done  = 1'b1;
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_d     = r_shift[0];
          w_shift = r_shift >> 1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_CLEAR;
      r_ldval <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_pcnt  <= '0;
      clr     <= 1'b0;
      pre     <= 1'b0;
      load    <= 1'b0;
      data    <= 1'b0;
      d       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_op    <= w_op;
      r_ldval <= w_ldval;
      r_shift <= w_shift;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_pcnt  <= w_pcnt;
      clr     <= w_pulse_on & (w_pop == OP_CLEAR);
      pre     <= w_pulse_on & (w_pop == OP_PRESET);
      load    <= w_pulse_on & (w_pop == OP_LOAD);
      data    <= w_pulse_on & (w_pop == OP_LOAD) & w_pval;
      d       <= w_d;
      busy    <= (w_state != S_IDLE);
      done    <= w_done;
    end
  end

endmodule
